key_pio: RTL and testbench
==========================

KEY_PIO -- requirements
Module: key_pio

Interface
REQ-001 SHALL have parameter BASE_ADR, default 16'hD010, base of the 4-byte register window.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, number of stable CLOCK_50 cycles that accepts a key change (10 ms).
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 res  input  1  reset, asynchronous, active-low.
REQ-005 phi  input  1  6502 phase clock, generated synchronously from CLOCK_50.
REQ-006 cpu_adr  input  16  CPU address bus.
REQ-007 cpu_dbo  input  8  CPU write data.
REQ-008 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-009 key_n  input  4  raw push-buttons, low when pressed, asynchronous.
REQ-010 sel  output  1  high when cpu_adr[15:2] == BASE_ADR[15:2]; used by the address decoder to mux pio_dbo onto cpu_dbi.
REQ-011 pio_dbo  output  8  read data; 8'h00 when sel = 0 or rw = 0.
REQ-012 irq_n  output  1  interrupt request to the CPU, active-low.
REQ-013 keys  output  4  debounced pressed state, for LED display.

Function
REQ-014 Each key_n bit SHALL pass through a 2-flop synchronizer; pressed = inverted synchronized value.
REQ-015 Per key, a counter SHALL increment while the synchronized value differs from the debounced state, clear when equal, and on reaching DEBOUNCE_CYCLES-1 the debounced state SHALL toggle and the counter SHALL clear; a single glitch shorter than DEBOUNCE_CYCLES resets the count.
REQ-016 A debounced 0->1 transition of key i SHALL set latch[i] on the same cycle the state toggles.
REQ-017 Register map (offset = cpu_adr[1:0]): 0 DATA RO = {4'b0, keys}; 1 STATUS = {|latch, 3'b0, latch}, write-1-to-clear bits [3:0]; 2 IRQEN = {4'b0, en}, R/W bits [3:0]; 3 reads 8'h00, writes ignored.
REQ-018 pio_dbo SHALL be combinational from cpu_adr, rw and register state (zero wait states).
REQ-019 A bus access SHALL commit on the single CLOCK_50 cycle where phi was 1 on the previous cycle and is 0 now (phi falling edge), with sel = 1; writes act only then, exactly once per CPU cycle.
REQ-020 Reads SHALL have no side effects.
REQ-021 Simultaneous press edge and W1C of the same bit SHALL leave latch bit set (set wins).
REQ-022 irq_n SHALL equal ~|(latch & en), registered, one CLOCK_50 cycle after the latch/en change.
REQ-023 Release edges SHALL NOT affect latch.

Reset
REQ-024 On res = 0, asynchronously: synchronizer flops 1, counters 0, keys 0, latch 0, en 0, irq_n 1, phi history 0.
REQ-025 Reset mid-debounce SHALL discard the partial count; after release a held key is accepted after a full DEBOUNCE_CYCLES and then sets its latch.
REQ-026 key_n[0] shares the top-level reset button; while res = 0 no key state is tracked.

Structure
REQ-027 Register offsets (PIO_DATA=0, PIO_STATUS=1, PIO_IRQEN=2) and NUM_KEYS=4 SHALL live in shared package computer_pkg.
REQ-028 One sub-module key_debounce (synchronizer + counter + state, one per key, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated NUM_KEYS times.
REQ-029 The top level SHALL add sel/pio_dbo into address_decode's cpu_dbi mux and drive the CPU irq from irq_n.

Verification (DEBOUNCE_CYCLES = 16)
REQ-030 Hold key_n = 4'b1101 for 20 cycles -> keys = 4'b0010 at 2 (sync) + 16 cycles after the change; STATUS reads 8'h82.
REQ-031 Pulse key_n[2] low for 10 cycles -> keys and latch stay 0.
REQ-032 Write IRQEN = 8'h02 with latch[1] set -> irq_n = 0 one cycle after commit; write STATUS = 8'h02 -> irq_n = 1 next cycle, STATUS reads 8'h00.
REQ-033 W1C of STATUS bit 3 committing on the exact cycle key 3 debounces pressed -> STATUS reads 8'h88.
REQ-034 Read offset 3 -> 8'h00; access to 16'hD014 -> sel = 0, pio_dbo = 8'h00; write with phi held at 1 (no falling edge) -> no register change.
REQ-035 Assert res = 0 mid-count and mid-interrupt -> irq_n = 1, keys = 0, en = 0 immediately without a clock edge.

Source files
------------

// File: rtl/computer_pkg.sv
// Shared constants for the computer's memory-mapped peripherals.
package computer_pkg;

    localparam int unsigned NUM_KEYS = 4;

    localparam logic [1:0] PIO_DATA   = 2'd0;
    localparam logic [1:0] PIO_STATUS = 2'd1;
    localparam logic [1:0] PIO_IRQEN  = 2'd2;

    // STATUS layout: summary bit on top, per-key latches in the low nibble.
    function automatic logic [7:0] pio_status(input logic [NUM_KEYS-1:0] latch);
        return {|latch, 3'b000, latch};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and debounced pressed state.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic res,
    input  logic key_n,
    output logic pressed,
    output logic press_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             differ_c;
    logic             expire_c;

    // sync[1] is the settled, active-low key level
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign differ_c = (~sync[1]) != pressed;
    assign expire_c = differ_c && (cnt == CNT_MAX);
    assign press_c  = expire_c && !pressed;

    // any cycle matching the current state restarts the stability window
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            if (!differ_c || expire_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (expire_c) begin
                pressed <= ~pressed;
            end
        end
    end

endmodule

// File: rtl/key_pio.sv
// Four-key parallel input port on the 6502 bus: debounced state, press latches and interrupt.
module key_pio
    import computer_pkg::*;
#(
    parameter logic [15:0] BASE_ADR        = 16'hD010,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                CLOCK_50,
    input  logic                res,
    input  logic                phi,
    input  logic [15:0]         cpu_adr,
    input  logic [7:0]          cpu_dbo,
    input  logic                rw,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                sel,
    output logic [7:0]          pio_dbo,
    output logic                irq_n,
    output logic [NUM_KEYS-1:0] keys
);

    logic                phi_q;
    logic [NUM_KEYS-1:0] latch;
    logic [NUM_KEYS-1:0] en;
    logic [NUM_KEYS-1:0] press_c;
    logic [NUM_KEYS-1:0] clr_c;
    logic                wr_c;
    logic                unused_c;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLOCK_50(CLOCK_50),
            .res     (res),
            .key_n   (key_n[g]),
            .pressed (keys[g]),
            .press_c (press_c[g])
        );
    end

    assign sel      = cpu_adr[15:2] == BASE_ADR[15:2];
    assign unused_c = ^cpu_dbo[7:NUM_KEYS];

    // writes take effect once per CPU cycle, on the phi falling edge
    assign wr_c  = phi_q && !phi && sel && !rw;
    assign clr_c = (wr_c && (cpu_adr[1:0] == PIO_STATUS)) ? cpu_dbo[NUM_KEYS-1:0] : '0;

    // zero-wait-state read mux
    always_comb begin
        pio_dbo = 8'h00;
        if (sel && rw) begin
            case (cpu_adr[1:0])
                PIO_DATA:   pio_dbo = {4'b0000, keys};
                PIO_STATUS: pio_dbo = pio_status(latch);
                PIO_IRQEN:  pio_dbo = {4'b0000, en};
                default:    pio_dbo = 8'h00;
            endcase
        end
    end

    // a press landing on the same cycle as its W1C keeps the latch set
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            phi_q <= 1'b0;
            latch <= '0;
            en    <= '0;
            irq_n <= 1'b1;
        end else begin
            phi_q <= phi;
            latch <= (latch & ~clr_c) | press_c;
            if (wr_c && (cpu_adr[1:0] == PIO_IRQEN)) begin
                en <= cpu_dbo[NUM_KEYS-1:0];
            end
            irq_n <= ~|(latch & en);
        end
    end

endmodule

// File: tb/tb_key_pio.sv
// Randomized and directed bench for key_pio against a sliding-window behavioural model.
module tb_key_pio;

    localparam int unsigned DB   = 16;
    localparam logic [15:0] BASE = 16'hD010;

    logic        CLOCK_50 = 1'b0;
    logic        res      = 1'b0;
    logic        phi      = 1'b0;
    logic [15:0] cpu_adr  = 16'h0000;
    logic [7:0]  cpu_dbo  = 8'h00;
    logic        rw       = 1'b1;
    logic [3:0]  key_n    = 4'hF;
    logic        sel;
    logic [7:0]  pio_dbo;
    logic        irq_n;
    logic [3:0]  keys;

    int checks = 0;
    int errors = 0;

    key_pio #(
        .BASE_ADR       (BASE),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .res     (res),
        .phi     (phi),
        .cpu_adr (cpu_adr),
        .cpu_dbo (cpu_dbo),
        .rw      (rw),
        .key_n   (key_n),
        .sel     (sel),
        .pio_dbo (pio_dbo),
        .irq_n   (irq_n),
        .keys    (keys)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a key flips once the last DB synchronized samples all disagree with it.
    logic [3:0] m_keys  = 4'h0;
    logic [3:0] m_latch = 4'h0;
    logic [3:0] m_en    = 4'h0;
    logic       m_irq_n = 1'b1;
    logic       m_phi_q = 1'b0;
    logic [3:0] hist[$];

    function automatic logic [7:0] m_read(input logic [15:0] a, input logic r);
        if (a[15:2] != BASE[15:2] || !r) return 8'h00;
        case (a[1:0])
            2'd0:    return {4'h0, m_keys};
            2'd1:    return {|m_latch, 3'b000, m_latch};
            2'd2:    return {4'h0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_keys  = 4'h0;
        m_latch = 4'h0;
        m_en    = 4'h0;
        m_irq_n = 1'b1;
        m_phi_q = 1'b0;
        hist.delete();
        repeat (DB + 2) hist.push_back(4'h0);
    endtask

    task automatic model_step();
        logic [3:0] nk, rise, clr, h;
        logic all_diff, commit;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(DB); k++) begin
                h = hist[hist.size() - 2 - k];
                if (h[i] == m_keys[i]) all_diff = 1'b0;
            end
            nk[i] = all_diff ? ~m_keys[i] : m_keys[i];
        end
        rise    = nk & ~m_keys;
        commit  = m_phi_q && !phi && (cpu_adr[15:2] == BASE[15:2]) && !rw;
        m_irq_n = ~|(m_latch & m_en);
        clr     = 4'h0;
        if (commit && cpu_adr[1:0] == 2'd1) clr = cpu_dbo[3:0];
        if (commit && cpu_adr[1:0] == 2'd2) m_en = cpu_dbo[3:0];
        m_latch = (m_latch & ~clr) | rise;
        m_keys  = nk;
        m_phi_q = phi;
        hist.push_back(~key_n);
        void'(hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLOCK_50);
            if (!res) model_reset();
            else model_step();
        end
    end

    // Continuous comparison mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (res) begin
                chk("keys", {4'h0, keys}, {4'h0, m_keys});
                chk("irq_n", {7'h0, irq_n}, {7'h0, m_irq_n});
                chk("sel", {7'h0, sel}, {7'h0, cpu_adr[15:2] == BASE[15:2]});
                chk("pio_dbo", pio_dbo, m_read(cpu_adr, rw));
            end else begin
                chk("rst_keys", {4'h0, keys}, 8'h00);
                chk("rst_irq_n", {7'h0, irq_n}, 8'h01);
                chk("rst_pio_dbo", pio_dbo, 8'h00);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_adr = a;
        cpu_dbo = d;
        rw      = 1'b0;
        phi     = 1'b1;
        tick();
        phi = 1'b0;
        tick();
        rw = 1'b1;
    endtask

    task automatic read_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
        cpu_adr = a;
        rw      = 1'b1;
        #1;
        chk(nm, pio_dbo, exp);
    endtask

    int hold;

    initial begin
        repeat (3) tick();
        chk("reset_keys", {4'h0, keys}, 8'h00);
        chk("reset_irq", {7'h0, irq_n}, 8'h01);
        read_chk("reset_status", 16'hD011, 8'h00);
        res = 1'b1;
        repeat (2) tick();

        // key 1 held for 20 cycles: accepted exactly 18 edges after the change
        key_n = 4'b1101;
        repeat (17) tick();
        chk("db_edge17", {4'h0, keys}, 8'h00);
        tick();
        chk("db_edge18", {4'h0, keys}, 8'h02);
        repeat (2) tick();
        key_n = 4'hF;
        read_chk("status_82", 16'hD011, 8'h82);
        repeat (25) tick();
        chk("released", {4'h0, keys}, 8'h00);
        read_chk("status_keep", 16'hD011, 8'h82);

        // short glitch is rejected
        key_n = 4'b1011;
        repeat (10) tick();
        key_n = 4'hF;
        repeat (25) tick();
        chk("glitch_keys", {4'h0, keys}, 8'h00);
        read_chk("glitch_status", 16'hD011, 8'h82);

        // enable then acknowledge the interrupt
        bus_write(16'hD012, 8'h02);
        chk("irq_commit", {7'h0, irq_n}, 8'h01);
        tick();
        chk("irq_set", {7'h0, irq_n}, 8'h00);
        bus_write(16'hD011, 8'h02);
        chk("irq_w1c_commit", {7'h0, irq_n}, 8'h00);
        tick();
        chk("irq_clear", {7'h0, irq_n}, 8'h01);
        read_chk("status_00", 16'hD011, 8'h00);

        // W1C of bit 3 on the exact cycle key 3 is accepted: set wins
        key_n = 4'b0111;
        repeat (16) tick();
        cpu_adr = 16'hD011;
        cpu_dbo = 8'h08;
        rw      = 1'b0;
        phi     = 1'b1;
        tick();
        chk("k3_edge17", {4'h0, keys}, 8'h00);
        phi = 1'b0;
        tick();
        rw = 1'b1;
        chk("k3_edge18", {4'h0, keys}, 8'h08);
        read_chk("status_88", 16'hD011, 8'h88);
        key_n = 4'hF;
        repeat (25) tick();

        // decode and commit qualification
        read_chk("offset3", 16'hD013, 8'h00);
        cpu_adr = 16'hD014;
        #1;
        chk("sel_out", {7'h0, sel}, 8'h00);
        chk("dbo_out", pio_dbo, 8'h00);
        cpu_adr = 16'hD012;
        cpu_dbo = 8'h0F;
        rw      = 1'b0;
        phi     = 1'b1;
        repeat (5) tick();
        rw  = 1'b1;
        phi = 1'b0;
        tick();
        read_chk("irqen_kept", 16'hD012, 8'h02);

        // asynchronous reset mid-interrupt and mid-count, then re-acceptance
        key_n = 4'b1101;
        repeat (20) tick();
        chk("pre_rst_irq", {7'h0, irq_n}, 8'h00);
        key_n = 4'b1001;
        repeat (8) tick();
        #1;
        res = 1'b0;
        #1;
        chk("arst_irq", {7'h0, irq_n}, 8'h01);
        chk("arst_keys", {4'h0, keys}, 8'h00);
        read_chk("arst_en", 16'hD012, 8'h00);
        tick();
        res = 1'b1;
        repeat (17) tick();
        chk("rel_edge17", {4'h0, keys}, 8'h00);
        tick();
        chk("rel_edge18", {4'h0, keys}, 8'h06);
        read_chk("rel_status", 16'hD011, 8'h86);
        key_n = 4'hF;
        repeat (25) tick();

        // randomized traffic
        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (hold == 0) begin
                key_n = 4'($urandom);
                hold  = int'($urandom_range(1, 40));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 2) == 0) phi = ~phi;
            case ($urandom_range(0, 5))
                0: cpu_adr = 16'hD010;
                1: cpu_adr = 16'hD011;
                2: cpu_adr = 16'hD012;
                3: cpu_adr = 16'hD013;
                4: cpu_adr = 16'hD014;
                default: cpu_adr = 16'($urandom);
            endcase
            rw      = 1'($urandom);
            cpu_dbo = 8'($urandom);
            res     = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
